// File: rtl/countdown_sequencer_pkg.sv
// countdown_pkg: the state type shared by the countdown sequencer and its bus.
//   IDLE - waiting for a load
//   RUN  - emitting indices
package countdown_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// countdown_sequencer_if: handshake bundle for the countdown sequencer.
//   load_valid/load_ready/load_count : load port (count N sampled on handshake)
//   abort                            : cancel a running sequence
//   idx_valid/idx_ready/idx/idx_last : index stream, N-1 down to 0
//   busy, done                       : status (done is a one-cycle pulse)
// master = the client driving loads and consuming indices, slave = the sequencer.
interface countdown_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_count;
    logic             abort;
    logic             idx_valid;
    logic             idx_ready;
    logic [WIDTH-1:0] idx;
    logic             idx_last;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_count, abort, idx_ready,
        input  load_ready, idx_valid, idx, idx_last, busy, done
    );

    modport slave (
        input  load_valid, load_count, abort, idx_ready,
        output load_ready, idx_valid, idx, idx_last, busy, done
    );
endinterface

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: loads a beat count N, then emits indices N-1 down to 0,
// one per accepted beat, and pulses done once per completed sequence
// (including N = 0). Used for reverse-order traversals.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : countdown_sequencer_if slave modport (load port, index stream, status)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | load_ready high; a load of N>0 starts RUN, N=0 pulses done
// RUN   | idx_valid/busy high; idx = index register, counts to 0
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    countdown_sequencer_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    if (bus.load_count != '0) begin
                        idx_d   = bus.load_count - WIDTH'(1);
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // abort wins over a beat handshaked in the same cycle
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.idx_ready) begin
                    // index 0 always leaves RUN, so the decrement never wraps
                    if (idx_q != '0) begin
                        idx_d = idx_q - WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Decoded from the state flop so reset clears valid/busy immediately.
    assign bus.load_ready = (state_q == IDLE);
    assign bus.idx_valid  = (state_q == RUN);
    assign bus.busy       = (state_q == RUN);
    assign bus.idx        = idx_q;
    assign bus.idx_last   = (state_q == RUN) && (idx_q == '0);
    assign bus.done       = done_q;

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Loadable down-counting index sequencer: accepts a beat count N over a valid/ready load port, then emits the indices N-1 down to 0, one per accepted beat, on a valid/ready output stream with a last flag. When the sequence completes it pulses done. It is the decrementing counterpart to the plain up counters used for loop indexing in the LCMV datapath, and drives reverse-order traversals such as back-substitution row indices.

## Interface

Parameters:
- WIDTH, 8, width of load count and emitted index; max sequence length 2^WIDTH-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  load request valid
- load_ready  out  1  block can accept a load (high only in IDLE)
- load_count  in  WIDTH  number of beats N to emit; sampled on load handshake
- abort  in  1  cancel running sequence
- idx_valid  out  1  idx/idx_last valid
- idx_ready  in  1  downstream accepts current idx
- idx  out  WIDTH  current index, N-1 down to 0
- idx_last  out  1  high when idx_valid and idx == 0
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on sequence completion

## Operation

- States: IDLE, RUN. Reset (rst low, asynchronous): state IDLE, index register 0, done 0. Outputs in reset: load_ready 1 after release (0 while rst low is not required; load_ready is combinational from state), idx_valid 0, idx 0, idx_last 0, busy 0, done 0.
- IDLE: load_ready = 1, idx_valid = 0. Load handshake (load_valid & load_ready):
  - load_count != 0: index register <= load_count - 1, state <= RUN.
  - load_count == 0: no beats; done pulses next cycle; state stays IDLE.
- RUN: load_ready = 0, idx_valid = 1, busy = 1, idx = index register, idx_last = (index register == 0).
  - abort high: state <= IDLE, no done pulse; abort overrides a simultaneous idx handshake (that beat counts as not transferred).
  - else idx handshake (idx_valid & idx_ready) with idx != 0: index register <= index - 1.
  - else idx handshake with idx == 0: state <= IDLE, done pulses next cycle.
  - idx_ready low: idx, idx_last held stable; idx_valid stays high (AXI-style, no retraction except on abort).
- abort in IDLE: ignored.
- load_valid during RUN: not accepted (load_ready low); upstream must hold.
- Arithmetic: decrement never wraps — the index == 0 case always leaves RUN. load_count = 2^WIDTH-1 yields 2^WIDTH-1 beats.
- done is a registered output; exactly one pulse per completed sequence, including N = 0.

## Timing

- Load accepted at edge k -> idx_valid high from cycle k+1, idx = N-1.
- With idx_ready held high: one beat per cycle, last beat in cycle k+N.
- Last beat accepted at edge m -> cycle m+1: state IDLE, done = 1, load_ready = 1 (a new load may be accepted at edge m+1). Minimum one-cycle gap between sequences.
- N = 0 load at edge k -> done = 1 in cycle k+1, load_ready remains 1 throughout.
- abort sampled at edge a -> idx_valid low from cycle a+1, done stays 0.
- rst asserted mid-RUN -> idx_valid, busy drop immediately (asynchronous); no done pulse.

## Structure

- Package countdown_pkg: state_t enum {IDLE, RUN}; nothing else shared.
- No sub-module; one state register, one WIDTH-bit index register, one done flop, combinational output decode.

## Test plan

- Reset then load_count = 4, idx_ready = 1 -> idx 3,2,1,0 on consecutive cycles, idx_last only on 0, done one cycle after 0 beat, busy high for exactly 4 cycles.
- load_count = 3, idx_ready toggling 1,0,0,1,1 -> idx held stable while ready low, sequence 2,1,0 completes, single done pulse.
- load_count = 0 -> no idx_valid, done pulses in next cycle, load_ready stays 1.
- load_count = 5, abort at second beat with idx_ready = 1 -> idx_valid low next cycle, no done, next load_count = 2 emits 1,0 correctly.
- WIDTH = 4, load_count = 15 -> 15 beats 14..0, no wrap to 15 after 0; load_valid held high during RUN not accepted until IDLE.
- rst pulsed low asynchronously mid-sequence (between edges) -> idx_valid, busy, done 0 immediately; after release load_ready = 1 and new sequence runs normally.
